// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_pkg
//  Purpose  : Shared definitions for the multicycle MIPS control FSM:
//             state encoding, supported opcodes, pc_src and alu_op codes.
//  Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGI  = 2'b11;

  // andi/ori use the zero-extended immediate with a logical ALU op
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_out_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_out_decode
//  Purpose  : Combinational state-to-control decode for mc_control.
//             Moore decode of the state, with pc_write/ir_write/retire
//             qualified by mem_ready or zero where the state requires it.
//  Ports    : reset_i, state_i, opcode_i, zero_i, mem_ready_i in;
//             all datapath selects, strobes and enables out.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_out_decode
  import mc_pkg::*;
(
  input  logic       reset_i,
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       i_or_d_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       imm_zext_o,
  output logic [1:0] alu_op_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       retire_o,
  output logic       illegal_o
);

  logic w_legal;
  assign w_legal = (opcode_i == OP_RTYPE) || (opcode_i == OP_LW) ||
                   (opcode_i == OP_SW)    || (opcode_i == OP_BEQ) ||
                   (opcode_i == OP_ADDI)  || (opcode_i == OP_ANDI) ||
                   (opcode_i == OP_ORI)   || (opcode_i == OP_J);

  always_comb begin
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    i_or_d_o     = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = PC_SRC_PC4;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 1'b0;
    imm_zext_o   = 1'b0;
    alu_op_o     = ALU_ADD;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    retire_o     = 1'b0;
    illegal_o    = 1'b0;

    // Reset forces every select and enable low, even mid-access
    if (!reset_i) begin
      case (state_i)
        S_FETCH: begin
          mem_read_o = 1'b1;
          ir_write_o = mem_ready_i;
          pc_write_o = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = 1'b1;
          illegal_o   = !w_legal;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        S_WB_R: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
          retire_o    = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 1'b1;
          imm_zext_o  = is_logic_imm(opcode_i);
          alu_op_o    = is_logic_imm(opcode_i) ? ALU_LOGI : ALU_ADD;
        end
        S_WB_I: begin
          // ALU result must stay stable through write-back
          imm_zext_o  = is_logic_imm(opcode_i);
          alu_op_o    = is_logic_imm(opcode_i) ? ALU_LOGI : ALU_ADD;
          reg_write_o = 1'b1;
          retire_o    = 1'b1;
        end
        S_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 1'b1;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          i_or_d_o   = 1'b1;
        end
        S_WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          retire_o     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          i_or_d_o    = 1'b1;
          retire_o    = mem_ready_i;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          pc_src_o    = PC_SRC_BR;
          pc_write_o  = zero_i;
          retire_o    = 1'b1;
        end
        S_JUMP: begin
          pc_src_o   = PC_SRC_J;
          pc_write_o = 1'b1;
          retire_o   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multicycle control FSM for the MIPS core. Sequences the shared
//             datapath one step per cycle, stretches memory accesses with a
//             ready handshake and counts retired instructions.
//  Ports    : clk, reset (sync, active-high), opcode, funct, zero, mem_ready
//             in; datapath selects/strobes, retire, illegal, retired_cnt out.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             imm_zext,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_cnt_q;

  // funct only matters to the downstream ALU decoder
  logic w_unused_funct;
  assign w_unused_funct = ^funct;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      retired_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                  state_d = S_EXEC_R;
          OP_LW, OP_SW:              state_d = S_ADDR;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
          OP_J:                      state_d = S_JUMP;
          default:                   state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .reset_i      (reset),
    .state_i      (state_q),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .i_or_d_o     (i_or_d),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .pc_src_o     (pc_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .imm_zext_o   (imm_zext),
    .alu_op_o     (alu_op),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .retire_o     (retire),
    .illegal_o    (illegal)
  );

  assign retired_cnt = retired_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Directed self-checking bench for mc_control. Control outputs
//             are packed into one word and compared against hand-derived
//             per-state constants. A second instance with CNT_W=4 shares the
//             stimulus so counter wrap can be observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0]  pc_src, alu_op;
  logic        alu_src_a, alu_src_b, imm_zext, reg_dst, mem_to_reg;
  logic        reg_write, retire, illegal;
  logic [31:0] retired_cnt;

  logic        m4_read, m4_write, m4_iord, m4_irw, m4_pcw;
  logic [1:0]  m4_pcs, m4_aop;
  logic        m4_asa, m4_asb, m4_zx, m4_rd, m4_m2r, m4_rw, m4_ret, m4_ill;
  logic [3:0]  retired_cnt4;

  always #5 clk = ~clk;

  mc_control #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retire(retire), .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  mc_control #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(m4_read), .mem_write(m4_write),
    .i_or_d(m4_iord), .ir_write(m4_irw), .pc_write(m4_pcw), .pc_src(m4_pcs),
    .alu_src_a(m4_asa), .alu_src_b(m4_asb), .imm_zext(m4_zx),
    .alu_op(m4_aop), .reg_dst(m4_rd), .mem_to_reg(m4_m2r),
    .reg_write(m4_rw), .retire(m4_ret), .illegal(m4_ill),
    .retired_cnt(retired_cnt4)
  );

  // {mr, mw, iord, irw, pcw, pcs[1:0], asa, asb, zx, aop[1:0], rd, m2r, rw, ret, ill}
  logic [17:0] w_ctl;
  assign w_ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, imm_zext, alu_op,
                  reg_dst, mem_to_reg, reg_write, retire, illegal};

  localparam logic [17:0] C_IDLE    = 18'b0_0_0_0_0_00_0_0_0_00_0_0_0_0_0;
  localparam logic [17:0] C_FETCH_R = 18'b1_0_0_1_1_00_0_0_0_00_0_0_0_0_0;
  localparam logic [17:0] C_FETCH_W = 18'b1_0_0_0_0_00_0_0_0_00_0_0_0_0_0;
  localparam logic [17:0] C_DEC     = 18'b0_0_0_0_0_00_0_1_0_00_0_0_0_0_0;
  localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_00_0_1_0_00_0_0_0_0_1;
  localparam logic [17:0] C_EXEC_R  = 18'b0_0_0_0_0_00_1_0_0_10_0_0_0_0_0;
  localparam logic [17:0] C_WB_R    = 18'b0_0_0_0_0_00_0_0_0_00_1_0_1_1_0;
  localparam logic [17:0] C_EXEC_OR = 18'b0_0_0_0_0_00_1_1_1_11_0_0_0_0_0;
  localparam logic [17:0] C_WB_OR   = 18'b0_0_0_0_0_00_0_0_1_11_0_0_1_1_0;
  localparam logic [17:0] C_ADDR    = 18'b0_0_0_0_0_00_1_1_0_00_0_0_0_0_0;
  localparam logic [17:0] C_MEM_RD  = 18'b1_0_1_0_0_00_0_0_0_00_0_0_0_0_0;
  localparam logic [17:0] C_WB_MEM  = 18'b0_0_0_0_0_00_0_0_0_00_0_1_1_1_0;
  localparam logic [17:0] C_MEM_WRW = 18'b0_1_1_0_0_00_0_0_0_00_0_0_0_0_0;
  localparam logic [17:0] C_BR_T    = 18'b0_0_0_0_1_01_1_0_0_01_0_0_0_1_0;
  localparam logic [17:0] C_BR_NT   = 18'b0_0_0_0_0_01_1_0_0_01_0_0_0_1_0;
  localparam logic [17:0] C_JUMP    = 18'b0_0_0_0_1_10_0_0_0_00_0_0_0_1_0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle, apply this cycle's handshake inputs, check controls
  task automatic cyc(input string tag, input logic rdy, input logic z, input logic [17:0] exp);
    tick();
    mem_ready = rdy;
    zero      = z;
    #1;
    chk(tag, {14'd0, w_ctl}, {14'd0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    opcode    = 6'b000000;
    funct     = 6'b100000;

    // Reset: everything low despite mem_ready=1
    tick(); chk("rst_c0", {14'd0, w_ctl}, {14'd0, C_IDLE});
    tick(); chk("rst_c1", {14'd0, w_ctl}, {14'd0, C_IDLE});
    chk("rst_cnt", retired_cnt, 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch0", {14'd0, w_ctl}, {14'd0, C_FETCH_R});
    chk("cnt0", retired_cnt, 32'd0);

    // R-type add
    opcode = 6'b000000;
    cyc("r_dec",  1'b1, 1'b0, C_DEC);
    cyc("r_exec", 1'b1, 1'b0, C_EXEC_R);
    cyc("r_wb",   1'b1, 1'b0, C_WB_R);
    cyc("r_fetch",1'b1, 1'b0, C_FETCH_R);
    chk("r_cnt", retired_cnt, 32'd1);

    // lw with two wait cycles in MEM_RD
    opcode = 6'b100011;
    cyc("lw_dec",   1'b1, 1'b0, C_DEC);
    cyc("lw_addr",  1'b1, 1'b0, C_ADDR);
    cyc("lw_rd0",   1'b0, 1'b0, C_MEM_RD);
    cyc("lw_rd1",   1'b0, 1'b0, C_MEM_RD);
    cyc("lw_rd2",   1'b1, 1'b0, C_MEM_RD);
    cyc("lw_wb",    1'b1, 1'b0, C_WB_MEM);
    cyc("lw_fetch", 1'b1, 1'b0, C_FETCH_R);
    chk("lw_cnt", retired_cnt, 32'd2);

    // beq taken, then not taken
    opcode = 6'b000100;
    cyc("beqt_dec",   1'b1, 1'b0, C_DEC);
    cyc("beqt_br",    1'b1, 1'b1, C_BR_T);
    cyc("beqt_fetch", 1'b1, 1'b0, C_FETCH_R);
    chk("beqt_cnt", retired_cnt, 32'd3);
    cyc("beqn_dec",   1'b1, 1'b0, C_DEC);
    cyc("beqn_br",    1'b1, 1'b0, C_BR_NT);
    cyc("beqn_fetch", 1'b1, 1'b0, C_FETCH_R);
    chk("beqn_cnt", retired_cnt, 32'd4);

    // ori
    opcode = 6'b001101;
    cyc("ori_dec",   1'b1, 1'b0, C_DEC);
    cyc("ori_exec",  1'b1, 1'b0, C_EXEC_OR);
    cyc("ori_wb",    1'b1, 1'b0, C_WB_OR);
    cyc("ori_fetch", 1'b1, 1'b0, C_FETCH_R);
    chk("ori_cnt", retired_cnt, 32'd5);

    // Unsupported opcode, then a stalled FETCH
    opcode = 6'b111111;
    cyc("ill_dec",    1'b1, 1'b0, C_DEC_ILL);
    cyc("ill_fetchw", 1'b0, 1'b0, C_FETCH_W);
    cyc("ill_fetchr", 1'b1, 1'b0, C_FETCH_R);
    chk("ill_cnt", retired_cnt, 32'd5);

    // j
    opcode = 6'b000010;
    cyc("j_dec",   1'b1, 1'b0, C_DEC);
    cyc("j_jump",  1'b1, 1'b0, C_JUMP);
    cyc("j_fetch", 1'b1, 1'b0, C_FETCH_R);
    chk("j_cnt", retired_cnt, 32'd6);

    // sw abandoned by reset while waiting in MEM_WR
    opcode = 6'b101011;
    cyc("sw_dec",  1'b1, 1'b0, C_DEC);
    cyc("sw_addr", 1'b1, 1'b0, C_ADDR);
    cyc("sw_wr0",  1'b0, 1'b0, C_MEM_WRW);
    cyc("sw_wr1",  1'b0, 1'b0, C_MEM_WRW);
    reset = 1'b1;
    #1;
    chk("sw_rst_drop", {14'd0, w_ctl}, {14'd0, C_IDLE});
    tick();
    chk("sw_rst_hold", {14'd0, w_ctl}, {14'd0, C_IDLE});
    chk("sw_rst_cnt", retired_cnt, 32'd0);
    chk("sw_rst_cnt4", {28'd0, retired_cnt4}, 32'd0);
    reset = 1'b0;
    #1;
    chk("sw_refetch_w", {14'd0, w_ctl}, {14'd0, C_FETCH_W});
    mem_ready = 1'b1;
    #1;
    chk("sw_refetch_r", {14'd0, w_ctl}, {14'd0, C_FETCH_R});

    // 16 jumps: 4-bit counter wraps 15 -> 0
    opcode = 6'b000010;
    for (int i = 0; i < 16; i++) begin
      cyc("wrap_dec",   1'b1, 1'b0, C_DEC);
      cyc("wrap_jump",  1'b1, 1'b0, C_JUMP);
      cyc("wrap_fetch", 1'b1, 1'b0, C_FETCH_R);
      chk("wrap_cnt4", {28'd0, retired_cnt4}, 32'((i + 1) % 16));
      chk("wrap_cnt32", retired_cnt, 32'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
